// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, canonical NOP and boot address.
package core_pkg;
  localparam int          XLEN            = 32;
  localparam logic [31:0] NOP_INST        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] DEF_RESET_ADDR  = 32'h0000_0000;

  // Word-align a byte address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: PC generation, synchronous-read imem drive and IF/ID register.
// One request is always in flight behind issue_pc; a halt freezes everything
// and drops ren so the memory keeps presenting the in-flight word.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = DEF_RESET_ADDR
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_halt,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_ren,
  output logic [XLEN-1:0] o_imem_raddr,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_id_valid,
  output logic [XLEN-1:0] o_id_inst,
  output logic [XLEN-1:0] o_id_pc,
  output logic [XLEN-1:0] o_id_pc4,
  output logic            o_flush
);

  logic [XLEN-1:0] issue_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight_valid;
  logic [XLEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;
  logic            id_valid;
  logic [XLEN-1:0] target;

  assign target       = word_align(i_redirect_pc);
  assign o_imem_raddr = i_redirect ? target : issue_pc;
  assign o_imem_ren   = !i_rst && (i_redirect || !i_halt);
  assign o_flush      = i_redirect;

  assign o_id_valid = id_valid;
  assign o_id_inst  = id_inst;
  assign o_id_pc    = id_pc;
  assign o_id_pc4   = id_pc + 32'd4;

  // Fetch state and IF/ID register: reset > redirect > halt > advance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      issue_pc       <= RESET_ADDR;
      inflight_pc    <= '0;
      inflight_valid <= 1'b0;
      id_inst        <= NOP_INST;
      id_pc          <= '0;
      id_valid       <= 1'b0;
    end else if (i_redirect) begin
      // Wrong-path word on rdata is dropped; target request goes out now.
      id_valid       <= 1'b0;
      id_inst        <= NOP_INST;
      inflight_pc    <= target;
      inflight_valid <= 1'b1;
      issue_pc       <= target + 32'd4;
    end else if (!i_halt) begin
      id_inst        <= inflight_valid ? i_imem_rdata : NOP_INST;
      id_pc          <= inflight_pc;
      id_valid       <= inflight_valid;
      inflight_pc    <= issue_pc;
      inflight_valid <= 1'b1;
      issue_pc       <= issue_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench for fetch_stage. The reference model tracks the program
// stream seen by ID: the next PC due in ID and how many empty slots remain
// before it arrives.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RA2 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst, halt, redir;
  logic [31:0] redir_pc;
  logic        ren, flush, id_valid;
  logic [31:0] raddr, rdata, id_inst, id_pc, id_pc4;

  logic        halt2 = 1'b0, redir2 = 1'b0;
  logic [31:0] redir_pc2 = '0;
  logic        ren2, flush2, id_valid2;
  logic [31:0] raddr2, rdata2, id_inst2, id_pc2, id_pc42;

  logic [31:0] salt = '0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .i_clk(clk), .i_rst(rst), .i_halt(halt), .i_redirect(redir),
    .i_redirect_pc(redir_pc), .o_imem_ren(ren), .o_imem_raddr(raddr),
    .i_imem_rdata(rdata), .o_id_valid(id_valid), .o_id_inst(id_inst),
    .o_id_pc(id_pc), .o_id_pc4(id_pc4), .o_flush(flush)
  );

  fetch_stage #(.RESET_ADDR(RA2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_halt(halt2), .i_redirect(redir2),
    .i_redirect_pc(redir_pc2), .o_imem_ren(ren2), .o_imem_raddr(raddr2),
    .i_imem_rdata(rdata2), .o_id_valid(id_valid2), .o_id_inst(id_inst2),
    .o_id_pc(id_pc2), .o_id_pc4(id_pc42), .o_flush(flush2)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ salt;
  endfunction

  // Synchronous-read memories; output holds while ren is low.
  always @(posedge clk) begin
    if (ren)  rdata  <= word(raddr);
    if (ren2) rdata2 <= raddr2;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference state
  bit          inited = 0;
  int          gap;          // empty ID slots still to come before m_next
  logic [31:0] m_next;       // next PC due in ID
  logic        m_valid;
  logic [31:0] m_pc, m_inst;
  int          c2 = -1;      // cycles since first release, for dut2

  task automatic step(input logic r, input logic h, input logic d, input logic [31:0] t);
    rst = r; halt = h; redir = d; redir_pc = t;
    @(negedge clk);
    chk("ren", {31'b0, ren}, {31'b0, !r && (d || !h)});
    chk("flush", {31'b0, flush}, {31'b0, d});
    if (inited && !r) begin
      chk("raddr", raddr, d ? {t[31:2], 2'b00} : (gap > 0 ? m_next : m_next + 32'd4));
    end
    if (inited) begin
      chk("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
      chk("id_inst", id_inst, m_valid ? m_inst : NOP);
      if (m_valid) begin
        chk("id_pc", id_pc, m_pc);
        chk("id_pc4", id_pc4, m_pc + 32'd4);
      end
    end
    if (c2 >= 2 && c2 <= 5) begin
      chk("wrap_valid", {31'b0, id_valid2}, 32'd1);
      chk("wrap_pc", id_pc2, RA2 + 32'd4 * (c2 - 2));
      chk("wrap_inst", id_inst2, RA2 + 32'd4 * (c2 - 2));
    end
    @(posedge clk);
    if (r) begin
      inited = 1; gap = 1; m_next = 32'h0; m_valid = 0; m_inst = NOP;
    end else if (d) begin
      m_valid = 0; m_inst = NOP; m_next = {t[31:2], 2'b00}; gap = 0;
    end else if (!h) begin
      if (gap > 0) begin
        gap--; m_valid = 0; m_inst = NOP;
      end else begin
        m_valid = 1; m_pc = m_next; m_inst = word(m_next); m_next = m_next + 32'd4;
      end
    end
    if (c2 >= 0 && c2 < 10) c2++;
    #1;
  endtask

  initial begin
    rst = 1; halt = 0; redir = 0; redir_pc = '0;
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    c2 = 0;
    // Run until pc 0x8 sits in ID, then halt three cycles.
    for (int i = 0; i < 20 && !(m_valid && m_pc == 32'h8); i++) step(0, 0, 0, 0);
    chk("reach_pc8", m_pc, 32'h8);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("after_halt_pc", id_pc, 32'hC);
    step(0, 0, 0, 0);
    // Redirect to 0x100.
    step(0, 0, 1, 32'h100);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Redirect and halt together, misaligned target.
    step(0, 1, 1, 32'h203);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Reset during a halt, then restart with a fresh memory image.
    step(0, 1, 0, 0);
    salt = 32'h5A5A_C3C3;
    step(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    // Random traffic; memory image only changes across a reset.
    for (int i = 0; i < 600; i++) begin
      logic r, h, d;
      logic [31:0] t;
      r = ($urandom_range(0, 99) < 2);
      h = ($urandom_range(0, 99) < 25);
      d = ($urandom_range(0, 99) < 10);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'hFFFF);
      if (r) salt = $urandom;
      step(r, h, d, t);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register. It generates the PC and drives a synchronous-read instruction memory. It also presents the decoded-stage instruction and PC to ID. It honours the IF/ID halt from the hazard detection unit and redirects from EX. It is the direct upstream producer of the instruction whose rs1/rs2/rd fields feed hazard detection, and it generates that unit's flush input.

## Interface
- RESET_ADDR, 32'h0000_0000: first fetch address after reset.
- i_clk  in  1  global clock.
- i_rst  in  1  synchronous, active-high reset.
- i_halt  in  1  hold PC and IF/ID register (from hazard unit IF/ID halt).
- i_redirect  in  1  taken branch/jump resolved in EX.
- i_redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 00).
- o_imem_ren  out  1  instruction memory read enable.
- o_imem_raddr  out  32  instruction memory byte address.
- i_imem_rdata  in  32  read data for the address accepted on the previous edge; memory holds rdata while ren=0.
- o_id_valid  out  1  IF/ID holds a real instruction.
- o_id_inst  out  32  IF/ID instruction; NOP (32'h0000_0013) when o_id_valid=0.
- o_id_pc  out  32  PC of o_id_inst.
- o_id_pc4  out  32  o_id_pc + 4, mod 2^32.
- o_flush  out  1  kill the instruction currently in ID; equals i_redirect (combinational).

## Operation
- State registers:
  - issue_pc: next address to request. Reset value RESET_ADDR.
  - inflight_pc / inflight_valid: the request whose data is on i_imem_rdata. Reset 0 / 0.
  - id_inst / id_pc / id_valid: the IF/ID register. Reset NOP / 0 / 0.
- Address mux: o_imem_raddr = i_redirect ? {i_redirect_pc[31:2],2'b00} : issue_pc.
- o_imem_ren = !i_rst & (i_redirect | !i_halt).
- Each cycle, with priority redirect > halt > normal:
  - **Redirect:**
    - id_valid<=0 and id_inst<=NOP.
    - inflight_pc<=target, inflight_valid<=1.
    - issue_pc<=target+4.
    - The data currently arriving is dropped.
  - **Halt (no redirect):**
    - All registers hold.
    - ren=0, so memory output holds and no fetched word is lost.
  - **Normal:**
    - id_inst<=inflight_valid ? i_imem_rdata : NOP.
    - id_pc<=inflight_pc, id_valid<=inflight_valid.
    - inflight_pc<=issue_pc, inflight_valid<=1.
    - issue_pc<=issue_pc+4.
- A NOP in ID has rd=rs1=rs2=x0, so it never creates a hazard.
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC+4 = 0.
- Reset mid-operation: on the next edge all state returns to reset values and any in-flight data is discarded. o_imem_ren=0 while i_rst is high.

## Timing
- Reset released before edge E0 (cycle 0):
  - Cycle 0: RESET_ADDR is issued.
  - Cycle 1: its data arrives.
  - Cycle 2: first o_id_valid=1 with o_id_pc=RESET_ADDR.
- Steady state: one instruction per cycle; o_id_pc advances by 4.
- Redirect in cycle N:
  - o_flush=1 in cycle N.
  - Cycle N+1: o_id_valid=0.
  - Cycle N+2: target in ID.
  - Penalty is 2 slots: the ID instruction at N and the wrong-path fetch.
- Halt for k cycles: ID outputs are frozen for exactly k cycles, then resume with the next sequential instruction. There is no duplicate and no skip.
- Halt and redirect in the same cycle: redirect wins.
- All outputs except o_imem_raddr, o_imem_ren and o_flush are registered.

## Structure
- Shared package core_pkg: XLEN=32, NOP_INST=32'h0000_0013, default RESET_ADDR.
- Single flat module. The IF/ID register is not split out; no sub-module is warranted.

## Test plan
- Reset release, memory returns word = addr: cycle 2 gives o_id_pc=0, o_id_inst=0; cycle 3 gives pc=4; o_id_valid stays 1.
- i_halt high for 3 cycles while ID holds pc=0x8: ID frozen at 0x8 for 3 cycles, o_imem_ren=0; then pc 0xC follows with no gap or duplicate.
- i_redirect in cycle N, target 0x100:
  - o_flush=1 in cycle N.
  - Cycle N+1: o_id_valid=0, o_id_inst=0x13.
  - Cycle N+2: o_id_pc=0x100, o_id_pc4=0x104.
- i_redirect and i_halt together, target 0x203: redirect wins; o_imem_raddr=0x200, ren=1; ID receives pc=0x200 at N+2.
- RESET_ADDR=32'hFFFF_FFF8: sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert i_rst mid-stream during a halt: next cycle o_id_valid=0 and o_id_inst=NOP; refetch restarts at RESET_ADDR with the same 2-cycle latency.
